// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with MTHI/MTLO writes applied in IDLE.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 sgn;
    logic                 dz;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign sgn   = ~op[0];
    assign dz    = op[1] && (b == '0);
    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

    // Multiply: prod_q holds {partial product, remaining multiplier bits}
    assign add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: the WIDTH+1-bit shifted remainder is compared before the subtract
    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
    assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;

    assign prod_fix = neg_q  ? -prod_q : prod_q;
    assign quo_fix  = neg_q  ? -quo_q  : quo_q;
    assign rem_fix  = rneg_q ? -rem_q  : rem_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    is_div_d = op[1];
                    count_d  = CW'(WIDTH);
                    state_d  = RUN;
                    if (op[1]) begin
                        // Divide by zero skips RUN; FIX then yields HI=a, LO=all ones
                        opnd_d = mag_b;
                        neg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]) & ~dz;
                        rneg_d = sgn & a[WIDTH-1] & ~dz;
                        rem_d  = dz ? a : '0;
                        quo_d  = dz ? '1 : mag_a;
                        if (dz) state_d = FIX;
                    end else begin
                        opnd_d = mag_a;
                        prod_d = {{WIDTH{1'b0}}, mag_b};
                        neg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d = 1'b0;
                    end
                end
            end
            RUN: begin
                count_d = count_q - 1'b1;
                if (is_div_q) begin
                    rem_d = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], rem_ge};
                end else begin
                    prod_d = {add_sum, prod_q[WIDTH-1:1]};
                end
                if (count_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
